// File: rtl/deparse_hdr_patcher_if.sv
// Bus between deparse_hdr_patcher (master) and sub_deparser (slave): PHV load,
// action strobe and the returned container.
interface deparse_hdr_patcher_if #(
  parameter int C_PHV_WIDTH        = 768,
  parameter int C_PARSE_ACTION_LEN = 6
);
  logic [C_PHV_WIDTH-1:0]        sub_phv_reg;
  logic                          sub_phv_reg_valid;
  logic [C_PARSE_ACTION_LEN-1:0] sub_parse_action;
  logic                          sub_parse_action_valid;
  logic [47:0]                   sub_phv_data;
  logic [1:0]                    sub_phv_select;
  logic                          sub_valid;

  modport master (
    output sub_phv_reg, sub_phv_reg_valid, sub_parse_action, sub_parse_action_valid,
    input  sub_phv_data, sub_phv_select, sub_valid
  );

  modport slave (
    input  sub_phv_reg, sub_phv_reg_valid, sub_parse_action, sub_parse_action_valid,
    output sub_phv_data, sub_phv_select, sub_valid
  );
endinterface

// File: rtl/deparse_hdr_patcher.sv
// Steps through a packet's action list, fetches each container from sub_deparser and
// patches it into the header window. Optional DEPARSE_PATCH_ERR_CNT_EN adds err_cnt.
module deparse_hdr_patcher #(
  parameter int C_HDR_WIDTH        = 1024,
  parameter int C_PHV_WIDTH        = 768,
  parameter int C_ACT_WIDTH        = 16,
  parameter int C_ACT_NUM          = 10,
  parameter int C_PARSE_ACTION_LEN = 6
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [C_HDR_WIDTH-1:0]         hdr_in,
  input  logic [C_PHV_WIDTH-1:0]         phv_in,
  input  logic [C_ACT_WIDTH*C_ACT_NUM-1:0] act_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  deparse_hdr_patcher_if.master          sub,
  output logic [C_HDR_WIDTH-1:0]         hdr_out,
  output logic                           hdr_out_err,
  output logic                           hdr_out_valid,
  input  logic                           hdr_out_ready
`ifdef DEPARSE_PATCH_ERR_CNT_EN
  ,
  output logic [15:0]                    err_cnt
`endif
);

  localparam int unsigned HDR_BYTES = C_HDR_WIDTH / 8;
  localparam int IDX_W = (C_ACT_NUM > 1) ? $clog2(C_ACT_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_ACT_NUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WAIT1, S_WAIT2, S_OUT} state_t;

  state_t                          state_q;
  logic [IDX_W-1:0]                idx_q;
  logic [C_HDR_WIDTH-1:0]          hdr_q;
  logic [C_ACT_WIDTH*C_ACT_NUM-1:0] act_q;
  logic [C_PHV_WIDTH-1:0]          phv_q;
  logic                            phv_vld_q;
  logic [C_PARSE_ACTION_LEN-1:0]   pact_q;
  logic                            pact_vld_q;
  logic                            err_q;
  logic                            in_ready_q;
  logic                            out_vld_q;
`ifdef DEPARSE_PATCH_ERR_CNT_EN
  logic [15:0]                     errcnt_q;
`endif

  logic [C_ACT_WIDTH-1:0] ent;
  logic [6:0]             ent_off;
  int unsigned            ent_size;
  logic                   ent_oob;
  logic                   ent_skip;
  logic                   last;
  logic [C_HDR_WIDTH-1:0] hdr_patched;
  int unsigned            nbytes;
  int unsigned            pos;
  logic                   unused_rsvd;

  // The entry under idx_q stays selected through WAIT2, so its offset drives the patch.
  always_comb begin
    ent     = act_q[C_ACT_WIDTH*idx_q +: C_ACT_WIDTH];
    ent_off = ent[12:6];
    case (ent[5:4])
      2'b01:   ent_size = 2;
      2'b10:   ent_size = 4;
      2'b11:   ent_size = 6;
      default: ent_size = 0;
    endcase
    ent_oob  = ent[0] && (ent[5:4] != 2'b00) && ((32'(ent_off) + ent_size) > HDR_BYTES);
    ent_skip = !ent[0] || (ent[5:4] == 2'b00) || ent_oob;
    last     = (idx_q == LAST_IDX);
  end

  assign unused_rsvd = ^ent[C_ACT_WIDTH-1:13];

  // Field byte 0 is the most significant byte of the returned container.
  always_comb begin
    hdr_patched = hdr_q;
    pos         = 0;
    case (sub.sub_phv_select)
      2'b01:   nbytes = 2;
      2'b10:   nbytes = 4;
      2'b11:   nbytes = 6;
      default: nbytes = 0;
    endcase
    for (int unsigned j = 0; j < 6; j++) begin
      pos = 32'(ent_off) + j;
      if (j < nbytes && pos < HDR_BYTES) begin
        hdr_patched[8*pos +: 8] = sub.sub_phv_data[8*(nbytes-1-j) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hdr_q      <= '0;
      act_q      <= '0;
      phv_q      <= '0;
      phv_vld_q  <= 1'b0;
      pact_q     <= '0;
      pact_vld_q <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      out_vld_q  <= 1'b0;
`ifdef DEPARSE_PATCH_ERR_CNT_EN
      errcnt_q   <= '0;
`endif
    end else begin
      phv_vld_q  <= 1'b0;
      pact_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            hdr_q      <= hdr_in;
            act_q      <= act_in;
            phv_q      <= phv_in;
            phv_vld_q  <= 1'b1;
            idx_q      <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (ent_skip) begin
            if (ent_oob) begin
              err_q <= 1'b1;
`ifdef DEPARSE_PATCH_ERR_CNT_EN
              if (errcnt_q != 16'hFFFF) errcnt_q <= errcnt_q + 16'd1;
`endif
            end
            if (last) begin
              out_vld_q <= 1'b1;
              state_q   <= S_OUT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            pact_q     <= ent[C_PARSE_ACTION_LEN-1:0];
            pact_vld_q <= 1'b1;
            state_q    <= S_WAIT1;
          end
        end
        S_WAIT1: state_q <= S_WAIT2;
        S_WAIT2: begin
          if (sub.sub_valid) begin
            hdr_q <= hdr_patched;
            if (last) begin
              out_vld_q <= 1'b1;
              state_q   <= S_OUT;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_SCAN;
            end
          end
        end
        S_OUT: begin
          if (hdr_out_ready) begin
            out_vld_q  <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready                   = in_ready_q;
  assign sub.sub_phv_reg            = phv_q;
  assign sub.sub_phv_reg_valid      = phv_vld_q;
  assign sub.sub_parse_action       = pact_q;
  assign sub.sub_parse_action_valid = pact_vld_q;
  assign hdr_out                    = hdr_q;
  assign hdr_out_err                = err_q;
  assign hdr_out_valid              = out_vld_q;
`ifdef DEPARSE_PATCH_ERR_CNT_EN
  assign err_cnt                    = errcnt_q;
`endif

endmodule

// File: tb/tb_deparse_hdr_patcher.sv
// Directed bench for deparse_hdr_patcher with a behavioural sub_deparser responder.
module tb_deparse_hdr_patcher;
  localparam int HW = 1024;
  localparam int PW = 768;
  localparam int AW = 16;
  localparam int AN = 10;
  localparam int PL = 6;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic [HW-1:0]  hdr_in = '0;
  logic [PW-1:0]  phv_in = '0;
  logic [AW*AN-1:0] act_in = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [HW-1:0]  hdr_out;
  logic           hdr_out_err;
  logic           hdr_out_valid;
  logic           hdr_out_ready = 1'b0;
`ifdef DEPARSE_PATCH_ERR_CNT_EN
  logic [15:0]    err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_errcnt = 0;
  bit resp_en = 1'b1;
  int stray_cnt = 0;
  logic [47:0] cont [8];

  deparse_hdr_patcher_if #(.C_PHV_WIDTH(PW), .C_PARSE_ACTION_LEN(PL)) sub_if ();

  deparse_hdr_patcher #(
    .C_HDR_WIDTH(HW), .C_PHV_WIDTH(PW), .C_ACT_WIDTH(AW),
    .C_ACT_NUM(AN), .C_PARSE_ACTION_LEN(PL)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .hdr_in(hdr_in), .phv_in(phv_in), .act_in(act_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .sub(sub_if),
    .hdr_out(hdr_out), .hdr_out_err(hdr_out_err),
    .hdr_out_valid(hdr_out_valid), .hdr_out_ready(hdr_out_ready)
`ifdef DEPARSE_PATCH_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // sub_deparser model: answers one cycle after the action strobe, or injects stray pulses.
  initial begin : responder
    logic [5:0] a;
    sub_if.sub_phv_data   = '0;
    sub_if.sub_phv_select = '0;
    sub_if.sub_valid      = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && sub_if.sub_parse_action_valid === 1'b1) begin
        a = sub_if.sub_parse_action;
        @(posedge clk); #1;
        sub_if.sub_phv_data   = cont[a[3:1]];
        sub_if.sub_phv_select = a[5:4];
        sub_if.sub_valid      = 1'b1;
        @(posedge clk); #1;
        sub_if.sub_valid      = 1'b0;
      end else if (stray_cnt > 0) begin
        sub_if.sub_phv_data   = 48'hFFFF_FFFF_FFFF;
        sub_if.sub_phv_select = 2'b11;
        sub_if.sub_valid      = 1'b1;
        @(negedge clk);
        sub_if.sub_valid      = 1'b0;
        stray_cnt--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ent(input logic [6:0] off, input logic [5:0] a);
    return {3'b000, off, a};
  endfunction

  function automatic int first_diff(input logic [HW-1:0] x, input logic [HW-1:0] y);
    for (int k = 0; k < HW/8; k++) if (x[8*k +: 8] !== y[8*k +: 8]) return k;
    return 0;
  endfunction

  task automatic send(input logic [HW-1:0] h, input logic [AW*AN-1:0] a, input logic [PW-1:0] p);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    hdr_in = h; act_in = a; phv_in = p; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat is the spec cycle number relative to the accept edge T, or -1 on timeout.
  task automatic wait_out(output int lat);
    int n = 0;
    lat = -1;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (hdr_out_valid === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic take_out();
    @(negedge clk);
    hdr_out_ready = 1'b1;
    @(posedge clk); #1;
    hdr_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, hdr_out_valid, hdr_out_err, sub_if.sub_phv_reg_valid, sub_if.sub_parse_action_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {in_ready, hdr_out_valid, hdr_out_err,
               sub_if.sub_phv_reg_valid, sub_if.sub_parse_action_valid});
    end
    checks++;
    if (hdr_out !== '0 || sub_if.sub_phv_reg !== '0 || sub_if.sub_parse_action !== '0) begin
      errors++;
      $display("FAIL reset_data got hdr[63:0]=%h phv[63:0]=%h act=%h want 0", hdr_out[63:0],
               sub_if.sub_phv_reg[63:0], sub_if.sub_parse_action);
    end
`ifdef DEPARSE_PATCH_ERR_CNT_EN
    checks++;
    if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
`endif
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_all_skip();
    logic [HW-1:0] h = {128{8'hAA}};
    int lat;
    send(h, '0, {96{8'h5A}});
    wait_out(lat);
    checks++;
    if (lat != 11) begin errors++; $display("FAIL skip_latency got %0d want 11", lat); end
    checks++;
    if (hdr_out !== h) begin
      errors++;
      $display("FAIL skip_hdr byte %0d got %h want %h", first_diff(hdr_out, h),
               hdr_out[8*first_diff(hdr_out, h) +: 8], h[8*first_diff(hdr_out, h) +: 8]);
    end
    checks++;
    if (hdr_out_err !== 1'b0) begin errors++; $display("FAIL skip_err got %b want 0", hdr_out_err); end
    take_out();
  endtask

  task automatic test_single_2b();
    logic [HW-1:0] h, exp;
    logic [AW*AN-1:0] a = '0;
    logic [PW-1:0] p = {96{8'hC7}};
    int lat;
    for (int k = 0; k < HW/8; k++) h[8*k +: 8] = 8'(k);
    exp = h;
    exp[8*12 +: 8] = 8'h08;
    exp[8*13 +: 8] = 8'h00;
    a[0 +: 16] = ent(7'd12, 6'b01_000_1);
    cont[0] = 48'h0000_0000_0800;
    send(h, a, p);
    checks++;
    if (sub_if.sub_phv_reg_valid !== 1'b1 || sub_if.sub_parse_action_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_phv_first got phv_vld=%b act_vld=%b want 1 0",
               sub_if.sub_phv_reg_valid, sub_if.sub_parse_action_valid);
    end
    checks++;
    if (sub_if.sub_phv_reg !== p) begin
      errors++;
      $display("FAIL single_phv_reg got %h want %h", sub_if.sub_phv_reg[63:0], p[63:0]);
    end
    wait_out(lat);
    checks++;
    if (lat != 13) begin errors++; $display("FAIL single_latency got %0d want 13", lat); end
    checks++;
    if (hdr_out !== exp) begin
      errors++;
      $display("FAIL single_hdr byte %0d got %h want %h", first_diff(hdr_out, exp),
               hdr_out[8*first_diff(hdr_out, exp) +: 8], exp[8*first_diff(hdr_out, exp) +: 8]);
    end
    checks++;
    if (sub_if.sub_parse_action !== 6'b01_000_1 || sub_if.sub_phv_reg_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_action got act=%b phv_vld=%b want 010001 0",
               sub_if.sub_parse_action, sub_if.sub_phv_reg_valid);
    end
    take_out();
  endtask

  task automatic test_overlap();
    logic [HW-1:0] h = {128{8'hAA}};
    logic [HW-1:0] exp;
    logic [AW*AN-1:0] a = '0;
    int lat;
    exp = h;
    exp[47:0] = 48'hEFBE_ADDE_2211;
    a[0 +: 16]  = ent(7'd0, 6'b11_001_1);
    a[48 +: 16] = ent(7'd2, 6'b10_010_1);
    cont[1] = 48'h1122_3344_5566;
    cont[2] = 48'h0000_DEAD_BEEF;
    send(h, a, '0);
    wait_out(lat);
    checks++;
    if (lat != 15) begin errors++; $display("FAIL overlap_latency got %0d want 15", lat); end
    checks++;
    if (hdr_out !== exp) begin
      errors++;
      $display("FAIL overlap_hdr byte %0d got %h want %h", first_diff(hdr_out, exp),
               hdr_out[8*first_diff(hdr_out, exp) +: 8], exp[8*first_diff(hdr_out, exp) +: 8]);
    end
    take_out();
  endtask

  task automatic test_oob();
    logic [HW-1:0] h = {128{8'h33}};
    logic [HW-1:0] exp;
    logic [AW*AN-1:0] a = '0;
    int lat;
    exp = h;
    exp[HW-1 -: 32] = 32'hEFBE_ADDE;
    a[0 +: 16]  = ent(7'd126, 6'b10_010_1);
    a[16 +: 16] = ent(7'd124, 6'b10_010_1);
    a[32 +: 16] = ent(7'd123, 6'b11_001_1);
    cont[2] = 48'h0000_DEAD_BEEF;
    send(h, a, '0);
    exp_errcnt += 2;
    wait_out(lat);
    checks++;
    if (lat != 13) begin errors++; $display("FAIL oob_latency got %0d want 13", lat); end
    checks++;
    if (hdr_out !== exp) begin
      errors++;
      $display("FAIL oob_hdr byte %0d got %h want %h", first_diff(hdr_out, exp),
               hdr_out[8*first_diff(hdr_out, exp) +: 8], exp[8*first_diff(hdr_out, exp) +: 8]);
    end
    checks++;
    if (hdr_out_err !== 1'b1) begin errors++; $display("FAIL oob_err got %b want 1", hdr_out_err); end
`ifdef DEPARSE_PATCH_ERR_CNT_EN
    checks++;
    if (err_cnt !== 16'(exp_errcnt)) begin errors++; $display("FAIL oob_err_cnt got %0d want %0d", err_cnt, exp_errcnt); end
`endif
    take_out();
  endtask

  task automatic test_backpressure();
    logic [HW-1:0] h  = {64{16'hC3A5}};
    logic [HW-1:0] h2 = {32{32'h0102_0304}};
    int lat;
    int bad = 0;
    send(h, '0, '0);
    wait_out(lat);
    checks++;
    if (lat != 11) begin errors++; $display("FAIL bp_latency got %0d want 11", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (hdr_out_valid !== 1'b1 || hdr_out !== h || in_ready !== 1'b0 || hdr_out_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stall_cycles got %0d bad cycles want 0", bad); end
    take_out();
    checks++;
    if (in_ready !== 1'b1 || hdr_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_handshake got in_ready=%b valid=%b want 1 0", in_ready, hdr_out_valid);
    end
    send(h2, '0, '0);
    checks++;
    if (in_ready !== 1'b0 || sub_if.sub_phv_reg_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept got in_ready=%b phv_vld=%b want 0 1", in_ready, sub_if.sub_phv_reg_valid);
    end
    wait_out(lat);
    checks++;
    if (lat != 11 || hdr_out !== h2) begin
      errors++;
      $display("FAIL bp_second_out got lat=%0d byte0=%h want lat=11 byte0=%h", lat, hdr_out[7:0], h2[7:0]);
    end
    take_out();
  endtask

  task automatic test_stray();
    logic [HW-1:0] h = {128{8'h5C}};
    int lat;
    stray_cnt = 1;
    repeat (3) @(posedge clk);
    send(h, '0, '0);
    stray_cnt = 3;
    wait_out(lat);
    checks++;
    if (lat != 11 || hdr_out !== h) begin
      errors++;
      $display("FAIL stray_ignored got lat=%0d byte %0d=%h want lat=11 byte=%h", lat,
               first_diff(hdr_out, h), hdr_out[8*first_diff(hdr_out, h) +: 8], h[8*first_diff(hdr_out, h) +: 8]);
    end
    take_out();
    stray_cnt = 0;
  endtask

  task automatic test_reset_mid();
    logic [AW*AN-1:0] a = '0;
    int seen = 0;
    resp_en = 1'b0;
    a[0 +: 16] = ent(7'd20, 6'b01_000_1);
    send({128{8'h77}}, a, {96{8'h11}});
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (hdr_out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stalled got valid=%b in_ready=%b want 0 0", hdr_out_valid, in_ready);
    end
    @(negedge clk);
    aresetn = 1'b0;
    exp_errcnt = 0;
    #1;
    checks++;
    if ({in_ready, hdr_out_valid, hdr_out_err, sub_if.sub_phv_reg_valid, sub_if.sub_parse_action_valid} !== 5'b0
        || hdr_out !== '0 || sub_if.sub_phv_reg !== '0 || sub_if.sub_parse_action !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got flags=%b hdr[63:0]=%h act=%h want 0", {in_ready, hdr_out_valid,
               hdr_out_err, sub_if.sub_phv_reg_valid, sub_if.sub_parse_action_valid}, hdr_out[63:0],
               sub_if.sub_parse_action);
    end
`ifdef DEPARSE_PATCH_ERR_CNT_EN
    checks++;
    if (err_cnt !== 16'(exp_errcnt)) begin errors++; $display("FAIL midrst_err_cnt got %0d want 0", err_cnt); end
`endif
    @(negedge clk);
    aresetn = 1'b1;
    resp_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (hdr_out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_no_output got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_all_skip();
    test_single_2b();
    test_overlap();
    test_oob();
    test_backpressure();
    test_stray();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deparse_hdr_patcher.md
# deparse_hdr_patcher

Sequencer and byte-patcher directly downstream of `sub_deparser` in the RMT deparser. Accepts one packet header window plus its PHV container block and action list, steps through the actions one by one, and issues each valid one to `sub_deparser`. Each returned 2B/4B/6B container is written into the header window at that action's byte offset. The patched header is then handed to the output stage with a valid/ready handshake.

## Interface
Parameters:
- `C_HDR_WIDTH`, 1024: header window width in bits. Byte k is `hdr[8k+:8]`, and byte 0 is first on the wire.
- `C_PHV_WIDTH`, 768: PHV container block width, matching `sub_deparser`'s PHV input.
- `C_ACT_WIDTH`, 16: width of one action entry.
- `C_ACT_NUM`, 10: number of actions per packet.
- `C_PARSE_ACTION_LEN`, 6: width of the `sub_deparser` action field.

Ports:
- `clk`  in  1  clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `hdr_in`  in  C_HDR_WIDTH  header window to patch.
- `phv_in`  in  C_PHV_WIDTH  PHV container block.
- `act_in`  in  C_ACT_WIDTH*C_ACT_NUM  action list. Entry i is `act_in[16i+:16]`:
  - [5:0] is the `sub_deparser` action ([0] valid, [3:1] index, [5:4] type 01=2B/10=4B/11=6B).
  - [12:6] is the byte offset.
  - [15:13] is reserved.
- `in_valid`  in  1  input bundle valid.
- `in_ready`  out  1  block can accept an input bundle.
- `sub_phv_reg`  out  C_PHV_WIDTH  to `sub_deparser` `deparse_phv_reg_in`.
- `sub_phv_reg_valid`  out  1  PHV load pulse to `sub_deparser`.
- `sub_parse_action`  out  C_PARSE_ACTION_LEN  to `sub_deparser` `parse_action`.
- `sub_parse_action_valid`  out  1  action strobe to `sub_deparser`.
- `sub_phv_data`  in  48  from `sub_deparser` `deparse_phv_reg_out`.
- `sub_phv_select`  in  2  from `sub_deparser` `deparse_phv_select`.
- `sub_valid`  in  1  from `sub_deparser` `valid_out`.
- `hdr_out`  out  C_HDR_WIDTH  patched header.
- `hdr_out_err`  out  1  at least one action of this packet was out of bounds.
- `hdr_out_valid`  out  1  output valid.
- `hdr_out_ready`  in  1  downstream ready.

## Operation
States: IDLE, SCAN, WAIT1, WAIT2, OUT.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register `hdr_in`, `act_in`, `phv_in`; `sub_phv_reg`<=`phv_in`; pulse `sub_phv_reg_valid` for 1 cycle; idx<=0; clear err; go to SCAN.
- **SCAN** (examines entry idx)
  - An entry is a **skip** when any of the following holds:
    - [0]=0;
    - [5:4]=00;
    - it is out of bounds, i.e. offset+size > C_HDR_WIDTH/8, where size is 2, 4 or 6 bytes.
  - Out-of-bounds entries also set err.
  - On skip: idx++ and stay in SCAN; if idx was C_ACT_NUM-1, go to OUT instead.
  - Otherwise: register `sub_parse_action`<=[5:0] and `sub_parse_action_valid`<=1; go to WAIT1.
- **WAIT1**
  - `sub_parse_action_valid`=1 for exactly this cycle.
  - Go to WAIT2.
- **WAIT2**
  - Holds until `sub_valid`=1.
  - Then patch field byte j into header byte offset+j, with j=0 taken as the MSB of `sub_phv_data`:
    - select 01: `sub_phv_data[15:8]`→offset, `[7:0]`→offset+1.
    - select 10: bits [31:0], 4 bytes.
    - select 11: bits [47:0], 6 bytes.
  - Then idx++; go to SCAN, or to OUT if this was the last entry.
- **OUT**
  - `hdr_out_valid`=1, with `hdr_out` and `hdr_out_err` held stable.
  - On `hdr_out_ready`: go to IDLE.
- Later actions overwrite earlier ones at overlapping bytes; actions apply in idx order.
- Bytes not covered by any action pass through unchanged.

## Timing
- **Reset values:** every output is 0 and the state is IDLE. A reset mid-packet discards the packet with no output.
- **Accept timing:** with the accept edge at cycle T, SCAN of entry 0 starts at T+1.
- **Per-entry cost:** a skip takes 1 cycle; a valid action takes 3 cycles (SCAN, WAIT1, WAIT2).
- **Latency:** `hdr_out_valid` rises at T+1+C_ACT_NUM+2·V, where V is the number of valid actions. With all 10 actions skipped, that is T+11.
- **PHV ordering:** `sub_phv_reg_valid` precedes the first `sub_parse_action_valid` by at least one cycle.
- **Back-to-back packets:** `in_ready` is 0 outside IDLE. `in_ready` returns to 1 in the cycle after the output handshake.
- **Output stability:** `hdr_out_valid` stalls indefinitely while `hdr_out_ready`=0, with data stable.
- **Stray `sub_valid`:** a `sub_valid` pulse outside WAIT2 is ignored.

## Configuration
- `DEPARSE_PATCH_ERR_CNT_EN`
  - Defined: adds output port `err_cnt` [15:0], a saturating count of out-of-bounds actions across packets. It increments once per offending entry in SCAN, holds at 16'hFFFF, and resets to 0 on reset.
  - Undefined: no counter and no port. `hdr_out_err` still works.

## Test plan
- **All actions skipped:** all `act_in`=0 and `hdr_in`=0xAA..AA → `hdr_out`=`hdr_in`, err=0, `hdr_out_valid` at T+11.
- **Single 2B patch:** entry 0 = offset 12, action 6'b01_000_1; container 0 holds 0x0800 → bytes 12/13 = 08/00, valid at T+13.
- **Overlapping patches:** entries 0 and 3 are 6B actions (6'b11_001_1) at offset 0 and a 4B action (6'b10_010_1) at offset 2; container data = 0x112233445566 and 0xDEADBEEF → bytes 0..5 = 11 22 DE AD BE EF.
- **Out-of-bounds action:** a 4B action at offset 126 → header unchanged, `hdr_out_err`=1, `err_cnt` +1 when the macro is defined.
- **Output backpressure:** hold `hdr_out_ready`=0 for 5 cycles → output stable, `in_ready`=0; after the handshake, a second bundle is accepted on the next cycle.
- **Reset mid-packet:** assert `aresetn`=0 during WAIT2 → all outputs 0, state IDLE, `in_ready`=1 after release.
